// File: rtl/bus_arbiter_ctrl.sv
// Single-master to N-slave registered bus controller: region decode, latched
// request phase, four-phase hello/ack handshake, unmapped error and ack watchdog.
module bus_arbiter_ctrl #(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int NUM_SLAVES  = 4,
  parameter int REGION_BITS = 12,
  parameter int TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WORD_W-1:0]            m_data_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic                         m_we_i,
  input  logic                         m_hello_i,
  output logic [WORD_W-1:0]            m_data_o,
  output logic                         m_ack_o,
  output logic                         m_err_o,
  output logic [WORD_W-1:0]            s_data_o,
  output logic [REGION_BITS-1:0]       s_addr_o,
  output logic                         s_we_o,
  output logic [NUM_SLAVES-1:0]        s_hello_o,
  input  logic [NUM_SLAVES-1:0]        s_ack_i,
  input  logic [NUM_SLAVES*WORD_W-1:0] s_data_i,
  output logic [1:0]                   dbg_state_o
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: m_hello_i is held by the master until it sees m_ack_o, then
  // dropped; m_ack_o falls one cycle later. s_hello_o[i] is held until the
  // addressed slave returns s_ack_i[i] (or the watchdog fires).
  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_cnt;

  logic [ADDR_W-1:0]     w_region;
  logic                  w_mapped;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_sel_ack;
  logic [WORD_W-1:0]     w_sel_data;
  logic                  w_timeout;
  logic [NUM_SLAVES-1:0] w_onehot;

  assign w_region    = m_addr_i >> REGION_BITS;
  assign w_mapped    = (w_region < ADDR_W'(NUM_SLAVES));
  assign w_idx       = w_region[IDX_W-1:0];
  assign w_onehot    = NUM_SLAVES'(1) << w_idx;
  assign w_sel_ack   = s_ack_i[r_idx];
  assign w_sel_data  = s_data_i[32'(r_idx)*WORD_W +: WORD_W];
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign dbg_state_o = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      m_data_o  <= '0;
      m_ack_o   <= 1'b0;
      m_err_o   <= 1'b0;
      s_data_o  <= '0;
      s_addr_o  <= '0;
      s_we_o    <= 1'b0;
      s_hello_o <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m_hello_i) begin
            if (w_mapped) begin
              s_addr_o  <= m_addr_i[REGION_BITS-1:0];
              s_data_o  <= m_data_i;
              s_we_o    <= m_we_i;
              r_idx     <= w_idx;
              s_hello_o <= w_onehot;
              r_cnt     <= '0;
              r_state   <= S_WAIT;
            end else begin
              m_ack_o  <= 1'b1;
              m_err_o  <= 1'b1;
              m_data_o <= '0;
              r_state  <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          // Ack is checked first so an ack in the final watchdog cycle still succeeds.
          if (w_sel_ack) begin
            s_hello_o <= '0;
            m_data_o  <= w_sel_data;
            m_ack_o   <= 1'b1;
            m_err_o   <= 1'b0;
            r_state   <= S_DONE;
          end else if (w_timeout) begin
            s_hello_o <= '0;
            m_data_o  <= '0;
            m_ack_o   <= 1'b1;
            m_err_o   <= 1'b1;
            r_state   <= S_DONE;
          end else if (TIMEOUT != 0) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (!m_hello_i) begin
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
